// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, status bit positions and transmitter states for mmio_uart_tx.
// MMIO_UART_TX_PARITY_EN adds the PARITY state.
package uart_mmio_pkg;

  localparam logic [2:0] TXDATA_OFF = 3'h0;
  localparam logic [2:0] STATUS_OFF = 3'h4;

  localparam int unsigned ST_FULL   = 0;
  localparam int unsigned ST_EMPTY  = 1;
  localparam int unsigned ST_BUSY   = 2;
  localparam int unsigned ST_OVF    = 3;
  localparam int unsigned ST_PARITY = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; dout shows the head entry combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // A pop in the same cycle frees the slot, so a push on full is still accepted.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores feed a byte FIFO drained as 8N1 frames on tx.
// Define MMIO_UART_TX_PARITY_EN for an even-parity bit (11-bit frames).
module mmio_uart_tx
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_from_alu,
  input  logic [31:0] data_to_write,
  input  logic        writting_to_mem,
  output logic [31:0] read_data,
  output logic        tx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             overflow, overflow_n;

  logic       hit;
  logic [2:0] off;
  logic       push_req;
  logic       ovf_clr;
  logic       pop;
  logic [7:0] fifo_dout;
  logic       full;
  logic       empty;
  logic       bit_done;
  logic [31:0] status;
  logic       unused_bits;

  // Address decode; the low two address bits are don't-care.
  assign hit      = (value_from_alu[31:3] == BASE_ADDR[31:3]);
  assign off      = {value_from_alu[2], 2'b00};
  assign push_req = writting_to_mem && hit && (off == TXDATA_OFF);
  assign ovf_clr  = writting_to_mem && hit && (off == STATUS_OFF) && data_to_write[3];
  assign unused_bits = ^{value_from_alu[1:0], data_to_write[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (data_to_write[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    status            = '0;
    status[ST_FULL]   = full;
    status[ST_EMPTY]  = empty;
    status[ST_BUSY]   = (state != IDLE);
    status[ST_OVF]    = overflow;
`ifdef MMIO_UART_TX_PARITY_EN
    status[ST_PARITY] = 1'b1;
`endif
  end

  assign read_data = (hit && (off == STATUS_OFF)) ? status : '0;
  assign bit_done  = (baud_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      overflow <= overflow_n;
    end
  end

  // Next state; tx is registered from the current state, so the line lags the FSM by one cycle.
  always_comb begin
    state_n    = state;
    baud_cnt_n = bit_done ? '0 : baud_cnt + CNT_W'(1);
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    pop        = 1'b0;
    tx_n       = 1'b1;
    overflow_n = overflow;

    if (ovf_clr) begin
      overflow_n = 1'b0;
    end else if (push_req && full && !pop) begin
      overflow_n = 1'b1;
    end

    case (state)
      IDLE: begin
        tx_n       = 1'b1;
        baud_cnt_n = '0;
        if (!empty) begin
          pop       = 1'b1;
          shreg_n   = fifo_dout;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_done) state_n = DATA;
      end
      DATA: begin
        tx_n = shreg[bit_idx];
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY: begin
        tx_n = ^shreg;
        if (bit_done) state_n = STOP;
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (bit_done) begin
          if (!empty) begin
            pop       = 1'b1;
            shreg_n   = fifo_dout;
            bit_idx_n = '0;
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Overflow depends on pop, so re-evaluate once pop is known.
    if (!ovf_clr && push_req && full && pop) overflow_n = overflow;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register decode table plus multi-cycle frame sequences.
module tb_mmio_uart_tx;

  localparam int unsigned CPB = 868;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value_from_alu = 32'h0;
  logic [31:0] data_to_write = 32'h0;
  logic        writting_to_mem = 1'b0;
  logic [31:0] read_data;
  logic        tx;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_rd;
    logic        exp_tx;
  } vec_t;

  vec_t vecs [11];

  mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_1000),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .value_from_alu  (value_from_alu),
    .data_to_write   (data_to_write),
    .writting_to_mem (writting_to_mem),
    .read_data       (read_data),
    .tx              (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic status_chk(input string name, input logic [31:0] exp);
    value_from_alu = 32'h0000_1004;
    #1;
    chk(name, read_data, exp);
  endtask

  // One-cycle store; returns at the negedge after the store edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    value_from_alu  = a;
    data_to_write   = d;
    writting_to_mem = 1'b1;
    @(negedge clk);
    writting_to_mem = 1'b0;
    value_from_alu  = 32'h0000_1004;
  endtask

  // Checks 10 bit periods of tx; each bit reports the number of wrong cycles.
  task automatic frame(input logic [7:0] d, input string name);
    logic [9:0] bits;
    int unsigned bad;
    bits = {1'b1, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < int'(CPB); c++) begin
        @(negedge clk);
        if (tx !== bits[b]) bad++;
      end
      chk($sformatf("%s bit%0d bad cycles", name, b), 32'(bad), 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1004, 32'h0,  1'b0, 32'h0000_0002, 1'b1};
    vecs[1]  = '{32'h0000_1000, 32'h0,  1'b0, 32'h0000_0000, 1'b1};
    vecs[2]  = '{32'h0000_1006, 32'h0,  1'b0, 32'h0000_0002, 1'b1};
    vecs[3]  = '{32'h0000_1008, 32'h0,  1'b0, 32'h0000_0000, 1'b1};
    vecs[4]  = '{32'h0000_0FFC, 32'h0,  1'b0, 32'h0000_0000, 1'b1};
    vecs[5]  = '{32'h0000_2004, 32'h0,  1'b0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{32'h0000_2000, 32'hFF, 1'b1, 32'h0000_0000, 1'b1};
    vecs[7]  = '{32'h0000_1004, 32'h0,  1'b0, 32'h0000_0002, 1'b1};
    vecs[8]  = '{32'h0000_1004, 32'h8,  1'b1, 32'h0000_0002, 1'b1};
    vecs[9]  = '{32'h0000_1005, 32'h0,  1'b0, 32'h0000_0002, 1'b1};
    vecs[10] = '{32'h0000_2000, 32'h0,  1'b0, 32'h0000_0000, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      value_from_alu  = vecs[i].addr;
      data_to_write   = vecs[i].wdata;
      writting_to_mem = vecs[i].we;
      #1;
      chk($sformatf("vec%0d read_data", i), read_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d tx", i), 32'(tx), 32'(vecs[i].exp_tx));
    end
    @(negedge clk);
    writting_to_mem = 1'b0;

    // Single byte 0x55
    store(32'h0000_1000, 32'h55);
    @(negedge clk);
    chk("single pre-start tx", 32'(tx), 32'd1);
    status_chk("single status after pop", 32'h0000_0006);
    frame(8'h55, "single");
    status_chk("single status idle", 32'h0000_0002);

    // Back-to-back 0xA5, 0x3C on consecutive cycles
    @(negedge clk);
    value_from_alu  = 32'h0000_1000;
    data_to_write   = 32'hA5;
    writting_to_mem = 1'b1;
    @(negedge clk);
    data_to_write   = 32'h3C;
    @(negedge clk);
    writting_to_mem = 1'b0;
    status_chk("b2b status one queued", 32'h0000_0004);
    chk("b2b pre-start tx", 32'(tx), 32'd1);
    frame(8'hA5, "b2b first");
    status_chk("b2b status after second pop", 32'h0000_0006);
    frame(8'h3C, "b2b second");
    status_chk("b2b status idle", 32'h0000_0002);

    // Reset mid-frame, with a second byte still queued
    store(32'h0000_1000, 32'h0F);
    store(32'h0000_1000, 32'h0F);
    repeat (5 * CPB + CPB / 2) @(negedge clk);
    chk("midreset tx before reset", 32'(tx), 32'd0);
    status_chk("midreset status before reset", 32'h0000_0004);
    reset = 1'b1;
    #1;
    chk("midreset tx async", 32'(tx), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    status_chk("midreset status after", 32'h0000_0002);
    begin
      int unsigned lows;
      lows = 0;
      repeat (3 * CPB) begin
        @(negedge clk);
        if (tx !== 1'b1) lows++;
      end
      chk("midreset residual low cycles", 32'(lows), 32'd0);
    end
    status_chk("midreset status still idle", 32'h0000_0002);

    // Overflow: 17 consecutive stores fill the FIFO behind the first popped byte
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      value_from_alu  = 32'h0000_1000;
      data_to_write   = 32'(i);
      writting_to_mem = 1'b1;
    end
    @(negedge clk);
    writting_to_mem = 1'b0;
    status_chk("ovf full no overflow", 32'h0000_0005);
    store(32'h0000_1000, 32'h11);
    status_chk("ovf 18th store", 32'h0000_000D);
    store(32'h0000_1004, 32'h7);
    status_chk("ovf store without bit3", 32'h0000_000D);
    store(32'h0000_1004, 32'h8);
    status_chk("ovf cleared", 32'h0000_0005);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    status_chk("ovf after reset", 32'h0000_0002);
    chk("ovf tx after reset", 32'(tx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
